// File: rtl/core_pipe_ctrl_if.sv
// Signal bundle between the pipeline control unit and the front-end, issue and commit blocks.
// The slave modport is the control unit's view; the master modport is the surrounding core's view.
interface core_pipe_ctrl_if #(
  parameter int NUM_RSV   = 4,
  parameter int RSV_IDX_W = 2,
  parameter int PC_W      = 32,
  parameter int CNT_W     = 16
);
  logic                 dec_valid;
  logic [RSV_IDX_W-1:0] dec_rsv_sel;
  logic [NUM_RSV-1:0]   rsv_full;
  logic                 rob_full;
  logic                 rob_empty;
  logic                 regmng_full;
  logic                 commit_valid;
  logic                 commit_mispred;
  logic [PC_W-1:0]      commit_target;
  logic                 redirect_ack;
  logic                 halt_req;
  logic                 resume_req;

  logic                 fetch_en;
  logic                 dec_stall;
  logic                 fe_flush;
  logic [NUM_RSV-1:0]   rsv_flush;
  logic                 be_flush;
  logic                 redirect_valid;
  logic [PC_W-1:0]      redirect_pc;
  logic                 halted;
  logic [2:0]           state;
  logic [CNT_W-1:0]     stall_cnt;
  logic [CNT_W-1:0]     flush_cnt;

  modport slave (
    input  dec_valid, dec_rsv_sel, rsv_full, rob_full, rob_empty, regmng_full,
           commit_valid, commit_mispred, commit_target, redirect_ack,
           halt_req, resume_req,
    output fetch_en, dec_stall, fe_flush, rsv_flush, be_flush, redirect_valid,
           redirect_pc, halted, state, stall_cnt, flush_cnt
  );

  modport master (
    output dec_valid, dec_rsv_sel, rsv_full, rob_full, rob_empty, regmng_full,
           commit_valid, commit_mispred, commit_target, redirect_ack,
           halt_req, resume_req,
    input  fetch_en, dec_stall, fe_flush, rsv_flush, be_flush, redirect_valid,
           redirect_pc, halted, state, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/core_pipe_ctrl.sv
// Pipeline control: back-pressure gating of fetch/decode, mispredict flush/redirect sequencing,
// halt/drain/resume, and saturating stall/flush statistics.
module core_pipe_ctrl #(
  parameter int NUM_RSV   = 4,
  parameter int RSV_IDX_W = 2,
  parameter int PC_W      = 32,
  parameter int FLUSH_CYC = 2,
  parameter int CNT_W     = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  core_pipe_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    RUN      = 3'd0,
    FLUSH    = 3'd1,
    REDIRECT = 3'd2,
    DRAIN    = 3'd3,
    HALTED   = 3'd4
  } state_t;

  state_t             state_q;
  logic [3:0]         flush_ctr;
  logic               halt_pending;
  logic [PC_W-1:0]    redirect_pc;
  logic               fe_flush;
  logic               be_flush;
  logic [NUM_RSV-1:0] rsv_flush;
  logic               redirect_valid;
  logic               halted;
  logic [CNT_W-1:0]   stall_cnt;
  logic [CNT_W-1:0]   flush_cnt;

  logic sel_full;
  logic run_stall;
  logic dec_stall;
  logic enter_flush;

  // A select that names no existing station matches no loop index and stays "full".
  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    sel_full = 1'b1;
    for (int i = 0; i < NUM_RSV; i++) begin
      if (RSV_IDX_W'(i) == bus.dec_rsv_sel) sel_full = bus.rsv_full[i];
    end
  end

  assign run_stall   = bus.dec_valid & (sel_full | bus.rob_full | bus.regmng_full);
  assign dec_stall   = (state_q == RUN) ? run_stall : 1'b1;
  assign enter_flush = bus.commit_valid & bus.commit_mispred &
                       ((state_q == RUN) | (state_q == DRAIN));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= RUN;
      flush_ctr      <= '0;
      halt_pending   <= 1'b0;
      redirect_pc    <= '0;
      fe_flush       <= 1'b0;
      be_flush       <= 1'b0;
      rsv_flush      <= '0;
      redirect_valid <= 1'b0;
      halted         <= 1'b0;
      stall_cnt      <= '0;
      flush_cnt      <= '0;
    end else begin
      if ((state_q == RUN) && run_stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end

      if (enter_flush) begin
        // Mispredict wins over halt; a mispredict while draining must come back to drain.
        state_q     <= FLUSH;
        flush_ctr   <= 4'(FLUSH_CYC - 1);
        redirect_pc <= bus.commit_target;
        fe_flush    <= 1'b1;
        be_flush    <= 1'b1;
        rsv_flush   <= '1;
        if (state_q == DRAIN) halt_pending <= 1'b1;
        if (flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
      end else begin
        unique case (state_q)
          RUN: begin
            if (bus.halt_req) state_q <= DRAIN;
          end
          FLUSH: begin
            if (flush_ctr == '0) begin
              state_q        <= REDIRECT;
              fe_flush       <= 1'b0;
              be_flush       <= 1'b0;
              rsv_flush      <= '0;
              redirect_valid <= 1'b1;
            end else begin
              flush_ctr <= flush_ctr - 1'b1;
            end
          end
          REDIRECT: begin
            if (bus.redirect_ack) begin
              redirect_valid <= 1'b0;
              state_q        <= (halt_pending | bus.halt_req) ? DRAIN : RUN;
            end
          end
          DRAIN: begin
            if (bus.rob_empty) begin
              state_q <= HALTED;
              halted  <= 1'b1;
            end
          end
          HALTED: begin
            if (bus.resume_req) begin
              state_q      <= RUN;
              halted       <= 1'b0;
              halt_pending <= 1'b0;
            end
          end
          default: state_q <= RUN;
        endcase
      end
    end
  end

  assign bus.dec_stall      = dec_stall;
  assign bus.fetch_en       = (state_q == RUN) & ~run_stall;
  assign bus.fe_flush       = fe_flush;
  assign bus.be_flush       = be_flush;
  assign bus.rsv_flush      = rsv_flush;
  assign bus.redirect_valid = redirect_valid;
  assign bus.redirect_pc    = redirect_pc;
  assign bus.halted         = halted;
  assign bus.state          = state_q;
  assign bus.stall_cnt      = stall_cnt;
  assign bus.flush_cnt      = flush_cnt;

endmodule

// File: tb/tb_core_pipe_ctrl.sv
// Directed bench for core_pipe_ctrl; a second instance with narrow counters exercises saturation.
`timescale 1ns/1ps
module tb_core_pipe_ctrl;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  core_pipe_ctrl_if #(.NUM_RSV(4), .RSV_IDX_W(2), .PC_W(32), .CNT_W(16)) bus ();
  core_pipe_ctrl_if #(.NUM_RSV(4), .RSV_IDX_W(2), .PC_W(32), .CNT_W(4))  bus_s ();

  core_pipe_ctrl #(.NUM_RSV(4), .RSV_IDX_W(2), .PC_W(32), .FLUSH_CYC(2), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  core_pipe_ctrl #(.NUM_RSV(4), .RSV_IDX_W(2), .PC_W(32), .FLUSH_CYC(2), .CNT_W(4)) dut_s (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_s.slave)
  );

  // The narrow-counter instance sees exactly the same stimulus.
  assign bus_s.dec_valid      = bus.dec_valid;
  assign bus_s.dec_rsv_sel    = bus.dec_rsv_sel;
  assign bus_s.rsv_full       = bus.rsv_full;
  assign bus_s.rob_full       = bus.rob_full;
  assign bus_s.rob_empty      = bus.rob_empty;
  assign bus_s.regmng_full    = bus.regmng_full;
  assign bus_s.commit_valid   = bus.commit_valid;
  assign bus_s.commit_mispred = bus.commit_mispred;
  assign bus_s.commit_target  = bus.commit_target;
  assign bus_s.redirect_ack   = bus.redirect_ack;
  assign bus_s.halt_req       = bus.halt_req;
  assign bus_s.resume_req     = bus.resume_req;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mispredict(input logic [31:0] target);
    bus.commit_valid   = 1'b1;
    bus.commit_mispred = 1'b1;
    bus.commit_target  = target;
  endtask

  task automatic clear_commit();
    bus.commit_valid   = 1'b0;
    bus.commit_mispred = 1'b0;
    bus.commit_target  = '0;
  endtask

  initial begin
    rst_n            = 1'b0;
    bus.dec_valid    = 1'b0;
    bus.dec_rsv_sel  = '0;
    bus.rsv_full     = '0;
    bus.rob_full     = 1'b0;
    bus.rob_empty    = 1'b0;
    bus.regmng_full  = 1'b0;
    bus.redirect_ack = 1'b0;
    bus.halt_req     = 1'b0;
    bus.resume_req   = 1'b0;
    clear_commit();

    // Reset state
    #3;
    check("rst_state", 32'(bus.state), 32'd0);
    check("rst_fe_flush", 32'(bus.fe_flush), 32'd0);
    check("rst_rsv_flush", 32'(bus.rsv_flush), 32'd0);
    check("rst_redirect_valid", 32'(bus.redirect_valid), 32'd0);
    check("rst_redirect_pc", bus.redirect_pc, 32'd0);
    check("rst_halted", 32'(bus.halted), 32'd0);
    check("rst_stall_cnt", 32'(bus.stall_cnt), 32'd0);
    check("rst_flush_cnt", 32'(bus.flush_cnt), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;

    // 1. Back-pressure from the selected station
    bus.dec_valid   = 1'b1;
    bus.dec_rsv_sel = 2'd2;
    bus.rsv_full    = 4'b0100;
    #1;
    check("t1_dec_stall", 32'(bus.dec_stall), 32'd1);
    check("t1_fetch_en", 32'(bus.fetch_en), 32'd0);
    tick();
    check("t1_stall_cnt1", 32'(bus.stall_cnt), 32'd1);
    tick();
    check("t1_stall_cnt2", 32'(bus.stall_cnt), 32'd2);
    tick();
    check("t1_stall_cnt3", 32'(bus.stall_cnt), 32'd3);
    bus.rsv_full = 4'b0000;
    #1;
    check("t1_clear_dec_stall", 32'(bus.dec_stall), 32'd0);
    check("t1_clear_fetch_en", 32'(bus.fetch_en), 32'd1);
    bus.dec_rsv_sel = 2'd3;
    bus.rsv_full    = 4'b0100;
    #1;
    check("t1_other_rsv_no_stall", 32'(bus.dec_stall), 32'd0);
    bus.rob_full = 1'b1;
    #1;
    check("t1_rob_full_stall", 32'(bus.dec_stall), 32'd1);
    bus.rob_full    = 1'b0;
    bus.regmng_full = 1'b1;
    #1;
    check("t1_regmng_stall", 32'(bus.dec_stall), 32'd1);
    bus.dec_valid = 1'b0;
    #1;
    check("t1_no_valid_no_stall", 32'(bus.dec_stall), 32'd0);
    bus.regmng_full = 1'b0;
    bus.rsv_full    = 4'b0000;

    // 2. Mispredict flush, redirect, return to RUN
    mispredict(32'h0000_1040);
    tick();
    check("t2_state_flush", 32'(bus.state), 32'd1);
    check("t2_fe_flush_c1", 32'(bus.fe_flush), 32'd1);
    check("t2_be_flush_c1", 32'(bus.be_flush), 32'd1);
    check("t2_rsv_flush_c1", 32'(bus.rsv_flush), 32'hF);
    check("t2_fetch_en_flush", 32'(bus.fetch_en), 32'd0);
    check("t2_dec_stall_flush", 32'(bus.dec_stall), 32'd1);
    check("t2_flush_cnt", 32'(bus.flush_cnt), 32'd1);
    mispredict(32'h0000_DEAD);
    tick();
    clear_commit();
    check("t2_fe_flush_c2", 32'(bus.fe_flush), 32'd1);
    check("t2_flush_cnt_ignored", 32'(bus.flush_cnt), 32'd1);
    tick();
    check("t2_state_redirect", 32'(bus.state), 32'd2);
    check("t2_fe_flush_done", 32'(bus.fe_flush), 32'd0);
    check("t2_rsv_flush_done", 32'(bus.rsv_flush), 32'd0);
    check("t2_redirect_valid", 32'(bus.redirect_valid), 32'd1);
    check("t2_redirect_pc", bus.redirect_pc, 32'h0000_1040);
    tick();
    check("t2_redirect_hold", 32'(bus.redirect_valid), 32'd1);
    bus.redirect_ack = 1'b1;
    tick();
    bus.redirect_ack = 1'b0;
    check("t2_state_run", 32'(bus.state), 32'd0);
    check("t2_redirect_valid_off", 32'(bus.redirect_valid), 32'd0);
    check("t2_stall_cnt_kept", 32'(bus.stall_cnt), 32'd3);

    // 3. Mispredict and halt together: flush first, then drain and halt
    mispredict(32'h0000_3000);
    bus.halt_req = 1'b1;
    tick();
    clear_commit();
    check("t3_state_flush", 32'(bus.state), 32'd1);
    tick();
    tick();
    check("t3_redirect_pc", bus.redirect_pc, 32'h0000_3000);
    bus.redirect_ack = 1'b1;
    tick();
    bus.redirect_ack = 1'b0;
    bus.halt_req     = 1'b0;
    check("t3_state_drain", 32'(bus.state), 32'd3);
    check("t3_drain_fetch_en", 32'(bus.fetch_en), 32'd0);
    check("t3_flush_cnt", 32'(bus.flush_cnt), 32'd2);
    tick();
    check("t3_drain_wait", 32'(bus.state), 32'd3);
    bus.rob_empty = 1'b1;
    tick();
    bus.rob_empty = 1'b0;
    check("t3_state_halted", 32'(bus.state), 32'd4);
    check("t3_halted", 32'(bus.halted), 32'd1);
    tick();
    check("t3_halted_hold", 32'(bus.state), 32'd4);
    bus.resume_req = 1'b1;
    tick();
    bus.resume_req = 1'b0;
    check("t3_state_run", 32'(bus.state), 32'd0);
    check("t3_halted_off", 32'(bus.halted), 32'd0);
    check("t3_fetch_en_run", 32'(bus.fetch_en), 32'd1);

    // resume outside HALTED has no effect
    bus.resume_req = 1'b1;
    tick();
    bus.resume_req = 1'b0;
    check("t3_resume_in_run", 32'(bus.state), 32'd0);

    // 4. Mispredict during drain returns to drain via halt_pending
    bus.halt_req = 1'b1;
    tick();
    bus.halt_req = 1'b0;
    check("t4_state_drain", 32'(bus.state), 32'd3);
    mispredict(32'h0000_2000);
    tick();
    clear_commit();
    check("t4_state_flush", 32'(bus.state), 32'd1);
    check("t4_flush_cnt", 32'(bus.flush_cnt), 32'd3);
    tick();
    tick();
    check("t4_state_redirect", 32'(bus.state), 32'd2);
    check("t4_redirect_pc", bus.redirect_pc, 32'h0000_2000);
    bus.redirect_ack = 1'b1;
    tick();
    bus.redirect_ack = 1'b0;
    check("t4_back_to_drain", 32'(bus.state), 32'd3);
    bus.rob_empty = 1'b1;
    tick();
    bus.rob_empty = 1'b0;
    check("t4_state_halted", 32'(bus.state), 32'd4);

    // halt_req held through resume re-enters DRAIN
    bus.halt_req   = 1'b1;
    bus.resume_req = 1'b1;
    tick();
    bus.resume_req = 1'b0;
    check("t4_resume_run", 32'(bus.state), 32'd0);
    tick();
    bus.halt_req = 1'b0;
    check("t4_rehalt_drain", 32'(bus.state), 32'd3);
    bus.rob_empty = 1'b1;
    tick();
    bus.rob_empty  = 1'b0;
    bus.resume_req = 1'b1;
    tick();
    bus.resume_req = 1'b0;
    check("t4_final_run", 32'(bus.state), 32'd0);
    check("t4_stall_cnt_kept", 32'(bus.stall_cnt), 32'd3);

    // 5. Counter saturation on the 4-bit instance (starts at 3, saturates at 0xF)
    bus.dec_valid = 1'b1;
    bus.rob_full  = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    check("t5_small_at_max", 32'(bus_s.stall_cnt), 32'hF);
    for (int i = 0; i < 5; i++) tick();
    check("t5_small_saturated", 32'(bus_s.stall_cnt), 32'hF);
    check("t5_wide_count", 32'(bus.stall_cnt), 32'd20);
    bus.dec_valid = 1'b0;
    bus.rob_full  = 1'b0;

    // 6. Asynchronous reset during FLUSH
    mispredict(32'h0000_4000);
    tick();
    clear_commit();
    check("t6_in_flush", 32'(bus.fe_flush), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_fe_flush_async", 32'(bus.fe_flush), 32'd0);
    check("t6_be_flush_async", 32'(bus.be_flush), 32'd0);
    check("t6_rsv_flush_async", 32'(bus.rsv_flush), 32'd0);
    check("t6_state_async", 32'(bus.state), 32'd0);
    check("t6_flush_cnt_async", 32'(bus.flush_cnt), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("t6_state_after_release", 32'(bus.state), 32'd0);
    check("t6_redirect_after_release", 32'(bus.redirect_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule
